// File: rtl/pisca_pkg.sv
// rtl/pisca_pkg.sv - shared types, defaults and helpers for the pisca scheduler
//
// Purpose : state encoding of the burst sequencer, default field widths and
//           the zero-length normalisation helper used when latching a burst.
// Contents: pisca_state_t  IDLE / ON / OFF / DONE
//           DEF_CNT_W      default phase-length width
//           DEF_REP_W      default repetition-count width
//           eff_len(x)     x when non-zero, otherwise 1

package pisca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } pisca_state_t;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_REP_W = 4;

  // Wide enough for any phase-length field; callers cast down to CNT_W.
  localparam int LEN_MAX_W = 32;

  // A zero phase length still occupies one cycle so every phase is visible.
  function automatic logic [LEN_MAX_W-1:0] eff_len(input logic [LEN_MAX_W-1:0] x);
    return (x != '0) ? x : LEN_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pisca_rr_arbiter.sv
// rtl/pisca_rr_arbiter.sv - combinational round-robin search over request bits
//
// Purpose : pick the first set request bit at or above ptr, wrapping from
//           N_REQ-1 back to 0. No state; the pointer lives in the scheduler.
// Ports   : req     in   N_REQ  request levels
//           ptr     in   PTR_W  index where the search starts
//           winner  out  N_REQ  one-hot winner, zero when nothing requests
//           valid   out  1      at least one request is set

module pisca_rr_arbiter
  import pisca_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  // Walk N_REQ positions starting at ptr; the first hit wins and later hits
  // are masked by valid.
  always_comb begin
    int j;
    winner = '0;
    valid  = 1'b0;
    j      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end
      if (!valid && req[j]) begin
        winner[j] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pisca_scheduler.sv
// rtl/pisca_scheduler.sv - round-robin sharing of one blinking LED among requesters
//
// Purpose : arbitrate among N_REQ requesters, latch the winner's burst shape
//           (on_len lit cycles, off_len dark cycles, repeated reps times),
//           play it on pisca, then pulse done for the winner and rotate.
// Ports   : clk      in   1            rising-edge clock
//           rst      in   1            synchronous active-high reset
//           req      in   N_REQ        request levels, held until done or abandon
//           on_len   in   N_REQ*CNT_W  lit-phase length per requester (slice i)
//           off_len  in   N_REQ*CNT_W  dark-phase length per requester (slice i)
//           reps     in   N_REQ*REP_W  repetition count per requester (slice i)
//           grant    out  N_REQ        one-hot owner, zero when idle
//           done     out  N_REQ        one-cycle one-hot completion pulse
//           pisca    out  1            shared LED drive
//           busy     out  1            high whenever the sequencer is not idle

module pisca_scheduler
  import pisca_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] on_len,
  input  logic [N_REQ*CNT_W-1:0] off_len,
  input  logic [N_REQ*REP_W-1:0] reps,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   pisca,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  pisca_state_t     state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] owner_q;
  logic [CNT_W-1:0] on_q;
  logic [CNT_W-1:0] off_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REP_W-1:0] rep_q;

  logic [N_REQ-1:0] win_oh;
  logic             win_valid;
  logic [PTR_W-1:0] win_idx;
  logic [CNT_W-1:0] on_sel;
  logic [CNT_W-1:0] off_sel;
  logic [REP_W-1:0] reps_sel;
  logic [CNT_W-1:0] eff_on_sel;
  logic [CNT_W-1:0] eff_off_sel;
  logic [PTR_W-1:0] next_ptr;
  logic             owner_req;

  pisca_rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win_oh),
    .valid  (win_valid)
  );

  // Slice the flattened buses with the one-hot winner; only meaningful in IDLE.
  always_comb begin
    win_idx  = '0;
    on_sel   = '0;
    off_sel  = '0;
    reps_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx  = PTR_W'(i);
        on_sel   = on_len[i*CNT_W +: CNT_W];
        off_sel  = off_len[i*CNT_W +: CNT_W];
        reps_sel = reps[i*REP_W +: REP_W];
      end
    end
  end

  assign eff_on_sel  = CNT_W'(eff_len(LEN_MAX_W'(on_sel)));
  assign eff_off_sel = CNT_W'(eff_len(LEN_MAX_W'(off_sel)));

  // Pointer advances past the owner whether the burst finished or was dropped.
  assign next_ptr  = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
  assign owner_req = req[owner_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      on_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      grant   <= '0;
      done    <= '0;
      pisca   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= '0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            grant   <= win_oh;
            owner_q <= win_idx;
            on_q    <= eff_on_sel;
            off_q   <= eff_off_sel;
            busy    <= 1'b1;
            if (reps_sel == '0) begin
              // Empty burst: skip straight to completion, LED never lights.
              state_q <= DONE;
              pisca   <= 1'b0;
              rep_q   <= '0;
            end else begin
              state_q <= ON;
              pisca   <= 1'b1;
              cnt_q   <= eff_on_sel - CNT_W'(1);
              rep_q   <= reps_sel;
            end
          end else begin
            grant <= '0;
            pisca <= 1'b0;
            busy  <= 1'b0;
          end
        end

        ON: begin
          if (!owner_req) begin
            state_q <= IDLE;
            grant   <= '0;
            pisca   <= 1'b0;
            busy    <= 1'b0;
            ptr_q   <= next_ptr;
          end else if (cnt_q == '0) begin
            state_q <= OFF;
            pisca   <= 1'b0;
            cnt_q   <= off_q - CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        OFF: begin
          if (!owner_req) begin
            state_q <= IDLE;
            grant   <= '0;
            pisca   <= 1'b0;
            busy    <= 1'b0;
            ptr_q   <= next_ptr;
          end else if (cnt_q == '0) begin
            if (rep_q == REP_W'(1)) begin
              state_q <= DONE;
            end else begin
              rep_q   <= rep_q - REP_W'(1);
              state_q <= ON;
              pisca   <= 1'b1;
              cnt_q   <= on_q - CNT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        DONE: begin
          // grant is still the owner here, so it doubles as the done vector.
          done    <= grant;
          grant   <= '0;
          pisca   <= 1'b0;
          busy    <= 1'b0;
          ptr_q   <= next_ptr;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          grant   <= '0;
          pisca   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pisca_scheduler.sv
// tb/tb_pisca_scheduler.sv - self-checking bench for pisca_scheduler

module tb_pisca_scheduler;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int RW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] on_len = '0;
  logic [N*CW-1:0] off_len = '0;
  logic [N*RW-1:0] reps = '0;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            pisca;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  pisca_scheduler #(.N_REQ(N), .CNT_W(CW), .REP_W(RW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .on_len  (on_len),
    .off_len (off_len),
    .reps    (reps),
    .grant   (grant),
    .done    (done),
    .pisca   (pisca),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: on each grant the whole burst is expanded into a queue
  // of per-cycle output slots; kind 1 = lit/dark slot (abandonable),
  // kind 2 = completion slot, kind 0 = idle / done-pulse slot.
  typedef struct {
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         pisca;
    logic         busy;
    int           kind;
  } slot_t;

  slot_t q[$];
  slot_t cur = '{'0, '0, 1'b0, 1'b0, 0};
  int    m_ptr = 0;
  int    m_owner = 0;
  bit    model_valid = 1'b0;

  always @(posedge clk) begin : model
    int eon, eoff, nr, j;
    bit found;
    slot_t s;
    cyc++;
    if (rst) begin
      q.delete();
      cur   = '{'0, '0, 1'b0, 1'b0, 0};
      m_ptr = 0;
    end else if (cur.kind == 1 && !req[m_owner]) begin
      q.delete();
      cur = '{'0, '0, 1'b0, 1'b0, 0};
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur   = '{'0, '0, 1'b0, 1'b0, 0};
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && req[j]) begin
          found = 1'b1;
          eon   = int'(on_len[j*CW +: CW]);
          eoff  = int'(off_len[j*CW +: CW]);
          nr    = int'(reps[j*RW +: RW]);
          if (eon == 0) eon = 1;
          if (eoff == 0) eoff = 1;
          for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < eon + eoff; c++) begin
              s = '{N'(1 << j), '0, (c < eon), 1'b1, 1};
              q.push_back(s);
            end
          end
          s = '{N'(1 << j), '0, 1'b0, 1'b1, 2};
          q.push_back(s);
          s = '{'0, N'(1 << j), 1'b0, 1'b0, 0};
          q.push_back(s);
          m_owner = j;
          m_ptr   = (j + 1) % N;
          cur     = q.pop_front();
        end
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge clk) begin : compare
    bit bad;
    if (model_valid) begin
      vectors++;
      bad = 1'b0;
      if (grant !== cur.grant) begin
        $display("FAIL cyc %0d grant act=%b exp=%b", cyc, grant, cur.grant);
        bad = 1'b1;
      end
      if (done !== cur.done) begin
        $display("FAIL cyc %0d done act=%b exp=%b", cyc, done, cur.done);
        bad = 1'b1;
      end
      if (pisca !== cur.pisca) begin
        $display("FAIL cyc %0d pisca act=%b exp=%b", cyc, pisca, cur.pisca);
        bad = 1'b1;
      end
      if (busy !== cur.busy) begin
        $display("FAIL cyc %0d busy act=%b exp=%b", cyc, busy, cur.busy);
        bad = 1'b1;
      end
      if (bad) miscompares++;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic set_lens(input int i, input int on, input int off, input int rp);
    on_len[i*CW +: CW]  = CW'(on);
    off_len[i*CW +: CW] = CW'(off);
    reps[i*RW +: RW]    = RW'(rp);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (grant == '0 && n < 40) begin
      step();
      n++;
    end
    check(name, 32'(grant != '0), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done == '0 && n < 60) begin
      step();
      n++;
    end
    check(name, 32'(done != '0), 32'd1);
  endtask

  initial begin : main
    logic [9:0] seq;
    logic [N-1:0] rr_exp [5];
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;

    // Reset state
    step();
    step();
    rst = 1'b0;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_pisca", 32'(pisca), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Single burst for requester 1: 3 lit, 2 dark, twice
    set_lens(1, 3, 2, 2);
    req = 4'b0010;
    step();
    seq = '0;
    for (int k = 0; k < 10; k++) begin
      seq = {seq[8:0], pisca};
      check("burst_grant", 32'(grant), 32'h2);
      step();
    end
    check("burst_pattern", 32'(seq), 32'b1110011100);
    check("burst_done_slot", 32'(done), 32'h0);
    step();
    check("burst_done_pulse", 32'(done), 32'h2);
    check("burst_done_grant", 32'(grant), 32'h0);
    req = '0;
    step();

    // Reset in the 2nd lit cycle; the pointer must return to 0
    set_lens(0, 3, 2, 2);
    req = 4'b0001;
    step();
    check("rst_on_grant", 32'(grant), 32'h1);
    step();
    rst = 1'b1;
    step();
    check("rst_pisca", 32'(pisca), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // Round-robin with all four requesting continuously
    for (int i = 0; i < N; i++) set_lens(i, 1, 1, 1);
    req = 4'b1111;
    step();
    for (int b = 0; b < 5; b++) begin
      wait_grant("rr_wait_grant");
      check("rr_order", 32'(grant), 32'(rr_exp[b]));
      wait_done("rr_wait_done");
      if (b == 4) req = '0;
      step();
    end

    // Abandon in the 2nd dark phase; pointer now 1 so requester 3 wins first
    set_lens(3, 5, 5, 3);
    set_lens(0, 1, 1, 1);
    req = 4'b1001;
    step();
    check("abandon_grant", 32'(grant), 32'h8);
    repeat (16) step();
    req = 4'b0001;
    step();
    check("abandon_pisca", 32'(pisca), 32'h0);
    check("abandon_grant0", 32'(grant), 32'h0);
    check("abandon_done", 32'(done), 32'h0);
    step();
    check("abandon_next", 32'(grant), 32'h1);
    wait_done("abandon_wait_done");
    req = '0;
    step();

    // Zero lengths: one lit cycle, one dark cycle
    set_lens(2, 0, 0, 1);
    req = 4'b0100;
    step();
    check("zero_p0", 32'(pisca), 32'h1);
    step();
    check("zero_p1", 32'(pisca), 32'h0);
    step();
    check("zero_slot", 32'(done), 32'h0);
    step();
    check("zero_done", 32'(done), 32'h4);
    req = '0;
    step();

    // Zero repetitions: no lit cycle, done two cycles after the grant edge
    set_lens(2, 3, 3, 0);
    req = 4'b0100;
    step();
    check("reps0_grant", 32'(grant), 32'h4);
    check("reps0_pisca", 32'(pisca), 32'h0);
    step();
    check("reps0_done", 32'(done), 32'h4);
    req = '0;
    step();

    // on_len changed mid-burst must not affect the latched burst
    set_lens(1, 4, 1, 2);
    req = 4'b0010;
    step();
    seq = '0;
    for (int k = 0; k < 10; k++) begin
      seq = {seq[8:0], pisca};
      if (k == 1) set_lens(1, 1, 1, 2);
      step();
    end
    check("latched_pattern", 32'(seq), 32'b1111011110);
    wait_done("latched_wait_done");
    req = '0;
    step();

    // Randomised traffic, abandons, parameter churn and occasional reset
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0)
          set_lens(i, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
        if (req[i]) begin
          if (done[i]) req[i] = 1'b0;
          else if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pisca_scheduler.md
Name: pisca_scheduler

Overview:
- Shares one blinking LED output among N_REQ requesters.
- Each requester asks for a burst: on_len cycles lit, off_len cycles dark, repeated reps times.
- A round-robin arbiter picks one requester. An FSM then plays that requester's latched pattern on `pisca`, pulses `done` for it, and moves on.
- The block is the sequencing and arbitration layer above the existing blinker datapath.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- CNT_W, 8, width of on_len/off_len phase lengths in cycles.
- REP_W, 4, width of the repetition count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until done or until the requester abandons.
- on_len  in  N_REQ*CNT_W  flattened; slice i = requester i lit-phase length.
- off_len  in  N_REQ*CNT_W  flattened; slice i = requester i dark-phase length.
- reps  in  N_REQ*REP_W  flattened; slice i = requester i repetition count.
- grant  out  N_REQ  one-hot owner; all-zero when idle.
- done  out  N_REQ  one-cycle one-hot completion pulse.
- pisca  out  1  shared LED drive.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, grant=0, done=0, pisca=0, busy=0, RR pointer=0, counters=0. Reset has priority over everything and aborts a service in progress with no done pulse.
- States: IDLE, ON, OFF, DONE. All outputs are registered.
- IDLE, no req: stay. pisca=0, grant=0.
- IDLE with any req at edge E:
  - Winner is the first set req bit searching upward from ptr, wrapping at N_REQ-1 → 0.
  - At E: grant=onehot(winner); latch the winner's on_len, off_len, reps; busy=1.
  - If latched reps=0 → DONE, pisca stays 0.
  - Otherwise → ON, pisca=1, phase counter=eff_on-1, rep_left=reps.
- Effective lengths: eff_on=max(on_len,1), eff_off=max(off_len,1). A zero length is treated as one cycle.
- ON: counter decrements each cycle. When counter==0 → OFF, pisca=0, counter=eff_off-1. pisca is therefore high for exactly eff_on cycles.
- OFF: counter decrements each cycle. When counter==0:
  - If rep_left==1 → DONE.
  - Otherwise rep_left-1, → ON, pisca=1, counter=eff_on-1.
- DONE (one cycle): done[winner]=1, grant=0, pisca=0, ptr=(winner+1) mod N_REQ; next state IDLE.
  - Minimum gap between bursts: DONE + IDLE = 2 cycles with pisca=0.
- Latency: req high before edge E → pisca=1 in the cycle after E. Burst length = reps*(eff_on+eff_off) cycles.
- Abandon: if req[winner]=0 at any edge while in ON or OFF:
  - → IDLE next edge, pisca=0, grant=0, no done pulse.
  - ptr=(winner+1) mod N_REQ.
- Input changes during service: changes to the owner's or others' on_len/off_len/reps are ignored (latched copy is used). Other req bits may toggle freely; they are only evaluated in IDLE.
- Simultaneous requests: resolved by ptr only. Fairness: a continuously requesting client waits at most N_REQ-1 bursts.
- Arithmetic: counters are unsigned CNT_W / REP_W and never underflow (checked ==0 before decrement).
- Invariants: grant is always zero- or one-hot; done is never set together with grant; pisca=1 only in ON.

Decomposition:
- Package pisca_pkg: state enum (IDLE, ON, OFF, DONE); default CNT_W/REP_W constants; helper function eff_len(x)=x?x:1.
- Sub-module pisca_rr_arbiter (N_REQ): inputs req and ptr; output one-hot winner and valid. Combinational search; the pointer register stays in the scheduler.
- Top pisca_scheduler holds the FSM, counters, latched parameters, and the slicing of the flattened buses.

Test Plan:
1. Reset mid-ON: req[0]=1, on=3, off=2, reps=2; assert rst in the 2nd ON cycle → next cycle pisca=0, grant=0, busy=0, no done; ptr back to 0.
2. Single burst: req[1]=1, on=3, off=2, reps=2, released on done → pisca pattern 1,1,1,0,0,1,1,1,0,0 from the cycle after grant edge; then done=0010 for 1 cycle; grant=0010 throughout the 10 cycles.
3. Round-robin: req=1111 held continuously, all on=1, off=1, reps=1 → grant order 0001, 0010, 0100, 1000, 0001. Each burst lasts 2 cycles plus 2-cycle gap.
4. Zero cases: req[2] with on=0, off=0, reps=1 → pisca 1,0 then done[2]. reps=0 → no pisca pulse; done[2] two cycles after grant edge.
5. Abandon: req[3] on=5, off=5, reps=3; drop req[3] in 2nd OFF → pisca=0, grant=0 next cycle, no done. A pending req[0] is granted in the following IDLE edge (ptr=0).
6. Param change mid-burst: change on_len[1] from 4 to 1 during ON → all remaining ON phases stay 4 cycles.
